// File: rtl/mem_backup_model_pkg.sv
// Shared types and width helpers for the harness backup-memory model.
// Widths never drop below 1 bit so single-entry geometries stay legal.
package mem_model_pkg;

    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_WRITE = 2'd1,
        MM_READ  = 2'd2
    } mm_state_e;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned beat_bits(input int unsigned beats);
        return idx_bits(beats);
    endfunction

    function automatic int unsigned line_bits(input int unsigned lines);
        return idx_bits(lines);
    endfunction

    function automatic int unsigned count_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_backup_model_if.sv
// Wide memory port: command, write-data and read-response channels.
interface mem_backup_model_if #(
    parameter int DATA_BITS = 128,
    parameter int ADDR_BITS = 26,
    parameter int TAG_BITS  = 5
);
    logic                 req_cmd_valid;
    logic                 req_cmd_ready;
    logic                 req_cmd_rw;
    logic [ADDR_BITS-1:0] req_cmd_addr;
    logic [TAG_BITS-1:0]  req_cmd_tag;
    logic                 req_data_valid;
    logic                 req_data_ready;
    logic [DATA_BITS-1:0] req_data_bits;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [TAG_BITS-1:0]  resp_tag;
    logic [DATA_BITS-1:0] resp_data;

    modport master (
        output req_cmd_valid, req_cmd_rw, req_cmd_addr, req_cmd_tag,
        output req_data_valid, req_data_bits, resp_ready,
        input  req_cmd_ready, req_data_ready, resp_valid, resp_tag, resp_data
    );

    modport slave (
        input  req_cmd_valid, req_cmd_rw, req_cmd_addr, req_cmd_tag,
        input  req_data_valid, req_data_bits, resp_ready,
        output req_cmd_ready, req_data_ready, resp_valid, resp_tag, resp_data
    );
endinterface

// File: rtl/mem_model_resp_fifo.sv
// Response FIFO with registered occupancy; the pushed entry becomes visible
// one cycle later, never in the same cycle.
module mem_model_resp_fifo import mem_model_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic [count_bits(DEPTH)-1:0]  count
);
    localparam int PTR_W = idx_bits(DEPTH);
    localparam int CNT_W = count_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/mem_backup_model.sv
// Backup memory behind the harness wide memory port: line-burst writes,
// credit-limited pipelined reads and sticky out-of-range reporting.
module mem_backup_model import mem_model_pkg::*; #(
    parameter int DATA_BITS    = 128,
    parameter int ADDR_BITS    = 26,
    parameter int TAG_BITS     = 5,
    parameter int BEATS        = 4,
    parameter int DEPTH_LINES  = 1024,
    parameter int READ_LATENCY = 4,
    parameter int RESP_DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_backup_model_if.slave  bus,
    output logic               busy,
    output logic               err_oob
);
    localparam int BEAT_W  = beat_bits(BEATS);
    localparam int LINE_W  = line_bits(DEPTH_LINES);
    localparam int RAM_W   = idx_bits(DEPTH_LINES * BEATS);
    localparam int CNT_W   = count_bits(RESP_DEPTH);
    localparam int BEAT_SH = $clog2(BEATS);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(RESP_DEPTH);

    localparam logic [1:0] ST_IDLE  = MM_IDLE;
    localparam logic [1:0] ST_WRITE = MM_WRITE;
    localparam logic [1:0] ST_READ  = MM_READ;

    logic [1:0]           state_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [LINE_W-1:0]    line_q;
    logic [TAG_BITS-1:0]  tag_q;
    logic                 oob_q;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     fifo_count;

    logic [DATA_BITS-1:0] ram [DEPTH_LINES*BEATS];
    logic [RAM_W-1:0]     ram_idx;
    logic [DATA_BITS-1:0] rd_data;

    logic cmd_hs, data_hs, cmd_oob, last_beat, credit_ok, issue, pop;
    logic                 push_vld;
    logic [TAG_BITS-1:0]  push_tag;
    logic [DATA_BITS-1:0] push_data;

    assign bus.req_cmd_ready  = reset_n && (state_q == ST_IDLE);
    assign bus.req_data_ready = (state_q == ST_WRITE);
    assign cmd_hs    = bus.req_cmd_valid && bus.req_cmd_ready;
    assign data_hs   = bus.req_data_valid && bus.req_data_ready;
    assign cmd_oob   = (bus.req_cmd_addr >> LINE_W) != '0;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    // Credit uses registered counts only, so a pop frees a slot one cycle late.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < CREDIT_MAX;
    assign issue     = (state_q == ST_READ) && credit_ok;

    assign ram_idx = (RAM_W'(line_q) << BEAT_SH) | RAM_W'(beat_q);
    assign rd_data = oob_q ? '0 : ram[ram_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            oob_q      <= 1'b0;
            err_oob    <= 1'b0;
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push_vld);
            if (cmd_hs && cmd_oob) err_oob <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        beat_q  <= '0;
                        oob_q   <= cmd_oob;
                        state_q <= bus.req_cmd_rw ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (data_hs) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            line_q <= bus.req_cmd_addr[LINE_W-1:0];
            tag_q  <= bus.req_cmd_tag;
        end
    end

    // Out-of-range writes complete the handshake but never touch the array.
    always_ff @(posedge clk) begin
        if (data_hs && !oob_q) ram[ram_idx] <= bus.req_data_bits;
    end

    // The FIFO register is the last latency stage: READ_LATENCY-1 stages here.
    generate
        if (READ_LATENCY == 1) begin : g_lat_direct
            assign push_vld  = issue;
            assign push_tag  = tag_q;
            assign push_data = rd_data;
        end else begin : g_lat_pipe
            logic                 vld_p  [READ_LATENCY-1];
            logic [TAG_BITS-1:0]  tag_p  [READ_LATENCY-1];
            logic [DATA_BITS-1:0] data_p [READ_LATENCY-1];

            for (genvar i = 0; i < READ_LATENCY - 1; i++) begin : g_stage
                if (i == 0) begin : g_first
                    always_ff @(posedge clk or negedge reset_n) begin
                        if (!reset_n) vld_p[i] <= 1'b0;
                        else          vld_p[i] <= issue;
                    end
                    always_ff @(posedge clk) begin
                        tag_p[i]  <= tag_q;
                        data_p[i] <= rd_data;
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge reset_n) begin
                        if (!reset_n) vld_p[i] <= 1'b0;
                        else          vld_p[i] <= vld_p[i-1];
                    end
                    always_ff @(posedge clk) begin
                        tag_p[i]  <= tag_p[i-1];
                        data_p[i] <= data_p[i-1];
                    end
                end
            end

            assign push_vld  = vld_p[READ_LATENCY-2];
            assign push_tag  = tag_p[READ_LATENCY-2];
            assign push_data = data_p[READ_LATENCY-2];
        end
    endgenerate

    assign bus.resp_valid = (fifo_count != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;

    mem_model_resp_fifo #(
        .WIDTH (TAG_BITS + DATA_BITS),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_vld),
        .push_data ({push_tag, push_data}),
        .pop       (pop),
        .pop_data  ({bus.resp_tag, bus.resp_data}),
        .count     (fifo_count)
    );

    assign busy = (state_q != ST_IDLE) || (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_mem_backup_model.sv
// Directed bench for mem_backup_model: default geometry plus a
// one-beat, one-cycle-latency, one-entry-FIFO instance.
module tb_mem_backup_model;
    localparam int DB = 128, AB = 26, TW = 5, NB = 4, DL = 1024, RL = 4, RD = 8;
    localparam int SDB = 32, SAB = 8, STW = 4, SDL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    mem_backup_model_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .TAG_BITS(TW)) bus ();
    mem_backup_model_if #(.DATA_BITS(SDB), .ADDR_BITS(SAB), .TAG_BITS(STW)) s_bus ();
    logic busy, err_oob, s_busy, s_err_oob;

    mem_backup_model #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .TAG_BITS(TW), .BEATS(NB),
        .DEPTH_LINES(DL), .READ_LATENCY(RL), .RESP_DEPTH(RD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .err_oob(err_oob)
    );

    mem_backup_model #(
        .DATA_BITS(SDB), .ADDR_BITS(SAB), .TAG_BITS(STW), .BEATS(1),
        .DEPTH_LINES(SDL), .READ_LATENCY(1), .RESP_DEPTH(1)
    ) sdut (
        .clk(clk), .reset_n(reset_n), .bus(s_bus), .busy(s_busy), .err_oob(s_err_oob)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DB-1:0] data;
        logic [31:0]   cyc;
    } resp_t;

    typedef struct packed {
        logic [STW-1:0] tag;
        logic [SDB-1:0] data;
        logic [31:0]    cyc;
    } s_resp_t;

    typedef struct packed {
        logic              rw;
        logic [AB-1:0]     addr;
        logic [TW-1:0]     tag;
        logic [NB-1:0][DB-1:0] d;
        logic              exp_err;
    } vec_t;

    resp_t   rq[$];
    s_resp_t s_rq[$];
    int unsigned max_occ = 0, s_max_occ = 0;

    always @(negedge clk) begin
        if (bus.resp_valid && bus.resp_ready) rq.push_back('{bus.resp_tag, bus.resp_data, cyc});
        if (s_bus.resp_valid && s_bus.resp_ready)
            s_rq.push_back('{s_bus.resp_tag, s_bus.resp_data, cyc});
        if (reset_n) begin
            if (32'(dut.fifo_count) + 32'(dut.inflight_q) > max_occ)
                max_occ = 32'(dut.fifo_count) + 32'(dut.inflight_q);
            if (32'(sdut.fifo_count) + 32'(sdut.inflight_q) > s_max_occ)
                s_max_occ = 32'(sdut.fifo_count) + 32'(sdut.inflight_q);
        end
    end

    task automatic check(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DB-1:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [NB-1:0][DB-1:0] mk(input logic [7:0] b0, b1, b2, b3);
        return {rep(b3), rep(b2), rep(b1), rep(b0)};
    endfunction

    // All driver tasks start and end one time unit after a rising edge.
    task automatic send_cmd(input logic rw, input logic [AB-1:0] addr,
                            input logic [TW-1:0] tag, output int unsigned t);
        int n = 0;
        bus.req_cmd_valid = 1'b1; bus.req_cmd_rw = rw;
        bus.req_cmd_addr = addr; bus.req_cmd_tag = tag;
        @(negedge clk);
        while (!bus.req_cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.req_cmd_ready) check("cmd_accept_timeout", 0, 1);
        t = cyc;
        @(posedge clk); #1;
        bus.req_cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DB-1:0] d);
        int n = 0;
        bus.req_data_valid = 1'b1; bus.req_data_bits = d;
        @(negedge clk);
        while (!bus.req_data_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.req_data_ready) check("data_accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.req_data_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AB-1:0] addr, input logic [TW-1:0] tag,
                            input logic [NB-1:0][DB-1:0] d);
        int unsigned t;
        send_cmd(1'b1, addr, tag, t);
        for (int b = 0; b < NB; b++) send_beat(d[b]);
    endtask

    task automatic get_resp(output resp_t r);
        int n = 0;
        while (rq.size() == 0 && n < 200) begin @(negedge clk); n++; end
        if (rq.size() == 0) begin
            check("resp_timeout", 0, 1);
            r = '0;
        end else r = rq.pop_front();
    endtask

    task automatic expect_beats(input string nm, input logic [TW-1:0] tag,
                                input logic [NB-1:0][DB-1:0] exp, input int unsigned first_cyc);
        resp_t r;
        for (int k = 0; k < NB; k++) begin
            get_resp(r);
            check($sformatf("%s_tag%0d", nm, k), DB'(r.tag), DB'(tag));
            check($sformatf("%s_data%0d", nm, k), r.data, exp[k]);
            if (k == 0) check($sformatf("%s_lat", nm), DB'(r.cyc), DB'(first_cyc));
        end
    endtask

    task automatic read_check(input string nm, input logic [AB-1:0] addr,
                              input logic [TW-1:0] tag, input logic [NB-1:0][DB-1:0] exp);
        int unsigned t;
        send_cmd(1'b0, addr, tag, t);
        expect_beats(nm, tag, exp, t + 1 + RL);
        @(posedge clk); #1;
    endtask

    task automatic s_send_cmd(input logic rw, input logic [SAB-1:0] addr,
                              input logic [STW-1:0] tag, output int unsigned t);
        int n = 0;
        s_bus.req_cmd_valid = 1'b1; s_bus.req_cmd_rw = rw;
        s_bus.req_cmd_addr = addr; s_bus.req_cmd_tag = tag;
        @(negedge clk);
        while (!s_bus.req_cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_bus.req_cmd_ready) check("s_cmd_accept_timeout", 0, 1);
        t = cyc;
        @(posedge clk); #1;
        s_bus.req_cmd_valid = 1'b0;
    endtask

    task automatic s_write(input logic [SAB-1:0] addr, input logic [SDB-1:0] d);
        int unsigned t;
        int n = 0;
        s_send_cmd(1'b1, addr, 4'd0, t);
        s_bus.req_data_valid = 1'b1; s_bus.req_data_bits = d;
        @(negedge clk);
        while (!s_bus.req_data_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_bus.req_data_ready) check("s_data_accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_bus.req_data_valid = 1'b0;
    endtask

    task automatic s_get_resp(output s_resp_t r);
        int n = 0;
        while (s_rq.size() == 0 && n < 200) begin @(negedge clk); n++; end
        if (s_rq.size() == 0) begin
            check("s_resp_timeout", 0, 1);
            r = '0;
        end else r = s_rq.pop_front();
    endtask

    vec_t tbl [7];
    logic [7:0] s_exp_tag [3];
    logic [SDB-1:0] s_exp_data [3];

    initial begin
        int unsigned t;
        resp_t r;
        s_resp_t sr;
        bit s_done;
        int n;

        tbl[0] = '{1'b1, 26'd3,    5'd5, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0};
        tbl[1] = '{1'b0, 26'd3,    5'd7, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0};
        tbl[2] = '{1'b1, 26'd2,    5'd1, mk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1'b0};
        tbl[3] = '{1'b0, 26'd1026, 5'd9, '0,                             1'b1};
        tbl[4] = '{1'b0, 26'd2,    5'd3, mk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1'b1};
        tbl[5] = '{1'b1, 26'd1026, 5'd2, mk(8'hFF, 8'hFE, 8'hFD, 8'hFC), 1'b1};
        tbl[6] = '{1'b0, 26'd2,    5'd4, mk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1'b1};

        reset_n = 1'b0;
        bus.req_cmd_valid = 0; bus.req_cmd_rw = 0; bus.req_cmd_addr = '0; bus.req_cmd_tag = '0;
        bus.req_data_valid = 0; bus.req_data_bits = '0; bus.resp_ready = 1'b1;
        s_bus.req_cmd_valid = 0; s_bus.req_cmd_rw = 0; s_bus.req_cmd_addr = '0; s_bus.req_cmd_tag = '0;
        s_bus.req_data_valid = 0; s_bus.req_data_bits = '0; s_bus.resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", DB'(bus.req_cmd_ready), 0);
        check("rst_data_ready", DB'(bus.req_data_ready), 0);
        check("rst_resp_valid", DB'(bus.resp_valid), 0);
        check("rst_busy", DB'(busy), 0);
        check("rst_err_oob", DB'(err_oob), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", DB'(bus.req_cmd_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rw) do_write(tbl[i].addr, tbl[i].tag, tbl[i].d);
            else read_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].tag, tbl[i].d);
            @(negedge clk);
            check($sformatf("vec%0d_err_oob", i), DB'(err_oob), DB'(tbl[i].exp_err));
            check($sformatf("vec%0d_busy", i), DB'(busy), 0);
            @(posedge clk); #1;
        end

        // Backpressure: three reads queued against a stalled consumer.
        bus.resp_ready = 1'b0;
        max_occ = 0;
        send_cmd(1'b0, 26'd3, 5'd10, t);
        send_cmd(1'b0, 26'd2, 5'd11, t);
        send_cmd(1'b0, 26'd3, 5'd12, t);
        repeat (40) begin @(posedge clk); #1; end
        @(negedge clk);
        check("bp_resp_valid", DB'(bus.resp_valid), 1);
        check("bp_busy", DB'(busy), 1);
        check("bp_nothing_popped", DB'(rq.size()), 0);
        check("bp_peak_occupancy", DB'(max_occ), DB'(RD));
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NB; k++) begin
                logic [NB-1:0][DB-1:0] e;
                e = (c == 1) ? mk(8'hA0, 8'hA1, 8'hA2, 8'hA3) : mk(8'h11, 8'h22, 8'h33, 8'h44);
                get_resp(r);
                check($sformatf("bp_tag_%0d_%0d", c, k), DB'(r.tag), DB'(10 + c));
                check($sformatf("bp_data_%0d_%0d", c, k), r.data, e[k]);
            end
        end
        @(posedge clk); #1;

        // Overlap: same-line write lands while the read is still in flight.
        send_cmd(1'b0, 26'd3, 5'd13, t);
        do_write(26'd3, 5'd14, mk(8'h55, 8'h66, 8'h77, 8'h88));
        expect_beats("ovl_old", 5'd13, mk(8'h11, 8'h22, 8'h33, 8'h44), t + 1 + RL);
        @(posedge clk); #1;
        read_check("ovl_new", 26'd3, 5'd15, mk(8'h55, 8'h66, 8'h77, 8'h88));

        // Reset after beat 1 of a line 9 rewrite.
        do_write(26'd9, 5'd1, mk(8'h90, 8'h91, 8'h92, 8'h93));
        send_cmd(1'b1, 26'd9, 5'd2, t);
        send_beat(rep(8'hC0));
        send_beat(rep(8'hC1));
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_ready", DB'(bus.req_cmd_ready), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready_after", DB'(bus.req_cmd_ready), 1);
        check("mid_rst_resp_valid", DB'(bus.resp_valid), 0);
        check("mid_rst_busy", DB'(busy), 0);
        check("mid_rst_err_oob", DB'(err_oob), 0);
        check("mid_rst_data_ready", DB'(bus.req_data_ready), 0);
        @(posedge clk); #1;
        read_check("partial_line9", 26'd9, 5'd6, mk(8'hC0, 8'hC1, 8'h92, 8'h93));

        // One-beat, latency-1, single-entry configuration.
        s_write(8'd5, 32'hCAFE_0005);
        s_write(8'd6, 32'h0BAD_0006);
        s_send_cmd(1'b0, 8'd5, 4'd6, t);
        s_get_resp(sr);
        check("s_rd_tag", DB'(sr.tag), 6);
        check("s_rd_data", DB'(sr.data), DB'(32'hCAFE_0005));
        check("s_rd_lat", DB'(sr.cyc), DB'(t + 2));
        @(posedge clk); #1;

        s_exp_tag[0] = 8'd1; s_exp_tag[1] = 8'd2; s_exp_tag[2] = 8'd3;
        s_exp_data[0] = 32'hCAFE_0005; s_exp_data[1] = 32'h0BAD_0006; s_exp_data[2] = 32'hCAFE_0005;
        s_bus.resp_ready = 1'b0;
        s_max_occ = 0;
        s_done = 1'b0;
        fork
            begin
                int unsigned ts;
                s_send_cmd(1'b0, 8'd5, 4'd1, ts);
                s_send_cmd(1'b0, 8'd6, 4'd2, ts);
                s_send_cmd(1'b0, 8'd5, 4'd3, ts);
                s_done = 1'b1;
            end
        join_none
        repeat (40) @(negedge clk);
        check("s_bp_peak_occupancy", DB'(s_max_occ), 1);
        check("s_bp_nothing_popped", DB'(s_rq.size()), 0);
        check("s_bp_busy", DB'(s_busy), 1);
        s_bus.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_get_resp(sr);
            check($sformatf("s_bp_tag%0d", c), DB'(sr.tag), DB'(s_exp_tag[c]));
            check($sformatf("s_bp_data%0d", c), DB'(sr.data), DB'(s_exp_data[c]));
        end
        n = 0;
        while (!s_done && n < 300) begin @(negedge clk); n++; end
        check("s_bp_sender_done", DB'(s_done), 1);
        repeat (3) @(negedge clk);
        check("s_bp_idle", DB'(s_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
